// File: rtl/draw_pkg.sv
// Shared widths, layer indices and sequencer state encoding
// for the frame draw controller.
package draw_pkg;

  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int COLOR_W = 12;

  localparam int LAYER_BG   = 0;
  localparam int LAYER_GOLD = 1;
  localparam int LAYER_HOOK = 2;
  localparam int LAYER_WIN  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_START,
    ST_WAIT,
    ST_FRAME_DONE
  } seq_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_pixel_mux.sv
// Registered select of one stage's pixel stream onto the VGA port.
// Ports: sel_i/active_i choose the source; vga_*_o are registered.
module draw_pixel_mux
  import draw_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int SEL_W      = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [SEL_W-1:0]              sel_i,
  input  logic                          active_i,
  input  logic [X_W*NUM_LAYERS-1:0]     layer_x_i,
  input  logic [Y_W*NUM_LAYERS-1:0]     layer_y_i,
  input  logic [COLOR_W*NUM_LAYERS-1:0] layer_color_i,
  input  logic [NUM_LAYERS-1:0]         layer_we_i,
  output logic [X_W-1:0]                vga_x_o,
  output logic [Y_W-1:0]                vga_y_o,
  output logic [COLOR_W-1:0]            vga_color_o,
  output logic                          vga_plot_o
);

  logic [X_W-1:0]     x_d, x_q;
  logic [Y_W-1:0]     y_d, y_q;
  logic [COLOR_W-1:0] c_d, c_q;
  logic               plot_d, plot_q;

  always_comb begin
    x_d    = layer_x_i[sel_i*X_W +: X_W];
    y_d    = layer_y_i[sel_i*Y_W +: Y_W];
    c_d    = layer_color_i[sel_i*COLOR_W +: COLOR_W];
    plot_d = active_i & layer_we_i[sel_i];
  end

  // Coordinates only move on a plotted pixel so the
  // adapter sees stable values between writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
      plot_q <= 1'b0;
    end else begin
      plot_q <= plot_d;
      if (plot_d) begin
        x_q <= x_d;
        y_q <= y_d;
        c_q <= c_d;
      end
    end
  end

  assign vga_x_o     = x_q;
  assign vga_y_o     = y_q;
  assign vga_color_o = c_q;
  assign vga_plot_o  = plot_q;

endmodule

// File: rtl/draw_sequencer.sv
// Frame draw controller: runs enabled stages in index order,
// muxes their pixels to VGA, watchdogs hung stages.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int TIMEOUT    = 8192
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          frame_tick,
  input  logic [NUM_LAYERS-1:0]         layer_mask,
  input  logic [X_W*NUM_LAYERS-1:0]     layer_x,
  input  logic [Y_W*NUM_LAYERS-1:0]     layer_y,
  input  logic [COLOR_W*NUM_LAYERS-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]         layer_we,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  output logic [NUM_LAYERS-1:0]         enable_draw,
  output logic [X_W-1:0]                vga_x,
  output logic [Y_W-1:0]                vga_y,
  output logic [COLOR_W-1:0]            vga_color,
  output logic                          vga_plot,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          frame_overrun,
  output logic [NUM_LAYERS-1:0]         layer_timeout
);

  localparam int SEL_W = sel_width(NUM_LAYERS);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_LAYERS - 1);

  seq_state_e            state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic                  pend_q, pend_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [NUM_LAYERS-1:0] to_q, to_d;
  logic                  ovr_q, ovr_d;

  logic done_sel;
  logic wd_hit;
  logic last;

  assign done_sel = layer_done[sel_q];
  assign wd_hit   = (wd_q == WD_MAX);
  assign last     = (sel_q == SEL_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    wd_d    = wd_q;
    to_d    = to_q;
    ovr_d   = 1'b0;

    // Requests outside IDLE queue one frame deep.
    if (frame_tick && state_q != ST_IDLE) begin
      pend_d = 1'b1;
      ovr_d  = pend_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick || pend_q) begin
          mask_d  = layer_mask;
          sel_d   = SEL_W'(LAYER_BG);
          pend_d  = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (mask_q[sel_q]) begin
          state_d = ST_START;
        end else if (last) begin
          state_d = ST_FRAME_DONE;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_sel || wd_hit) begin
          if (!done_sel) begin
            to_d[sel_q] = 1'b1;
          end
          if (last) begin
            state_d = ST_FRAME_DONE;
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = ST_SCAN;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_FRAME_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      pend_q  <= 1'b0;
      wd_q    <= '0;
      to_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    enable_draw = '0;
    if (state_q == ST_START) begin
      enable_draw[sel_q] = 1'b1;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = (state_q == ST_FRAME_DONE);
  assign frame_overrun = ovr_q;
  assign layer_timeout = to_q;

  draw_pixel_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .SEL_W      (SEL_W)
  ) u_mux (
    .clk           (clk),
    .resetn        (resetn),
    .sel_i         (sel_q),
    .active_i      (state_q == ST_WAIT),
    .layer_x_i     (layer_x),
    .layer_y_i     (layer_y),
    .layer_color_i (layer_color),
    .layer_we_i    (layer_we),
    .vga_x_o       (vga_x),
    .vga_y_o       (vga_y),
    .vga_color_o   (vga_color),
    .vga_plot_o    (vga_plot)
  );

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with stage models and a
// pixel scoreboard; all sampling is 1 time unit after posedge.
module tb_draw_sequencer;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          frame_tick = 1'b0;
  logic [NL-1:0] layer_mask = '0;
  logic [9*NL-1:0]  layer_x = '0;
  logic [8*NL-1:0]  layer_y = '0;
  logic [12*NL-1:0] layer_color = '0;
  logic [NL-1:0] layer_we = '0;
  logic [NL-1:0] layer_done = '0;
  logic [NL-1:0] enable_draw;
  logic [8:0]    vga_x;
  logic [7:0]    vga_y;
  logic [11:0]   vga_color;
  logic          vga_plot;
  logic          busy;
  logic          frame_done;
  logic          frame_overrun;
  logic [NL-1:0] layer_timeout;

  draw_sequencer #(.NUM_LAYERS(NL), .TIMEOUT(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .layer_mask    (layer_mask),
    .layer_x       (layer_x),
    .layer_y       (layer_y),
    .layer_color   (layer_color),
    .layer_we      (layer_we),
    .layer_done    (layer_done),
    .enable_draw   (enable_draw),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_color     (vga_color),
    .vga_plot      (vga_plot),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .layer_timeout (layer_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] x;
    logic [7:0] y;
    logic [11:0] c;
  } pix_t;

  pix_t     exp_q[$];
  logic [NL-1:0] en_log[$];
  int       en_cyc[$];
  int       errors = 0;
  int       checks = 0;
  int       cyc = 0;
  int       ph[NL];
  int       done_cyc[NL];
  int       fd_cnt, fd_cyc, ov_cnt, plot_cnt, to_cyc;
  logic [NL-1:0] hang = '0;
  logic     spur_en = 1'b0;
  logic     tick_req = 1'b0;
  int       t0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] px_x(input int i, input int k);
    if (i == 3 && k == 3) return 9'd319;
    return 9'(i * 70 + k * 5 + 1);
  endfunction

  function automatic logic [7:0] px_y(input int i, input int k);
    if (i == 3 && k == 3) return 8'd239;
    return 8'(i * 50 + k * 3 + 2);
  endfunction

  function automatic logic [11:0] px_c(input int i, input int k);
    return 12'(i * 256 + k * 16 + 5);
  endfunction

  task automatic clr();
    en_log.delete();
    en_cyc.delete();
    fd_cnt   = 0;
    fd_cyc   = -1;
    ov_cnt   = 0;
    plot_cnt = 0;
    to_cyc   = -1;
  endtask

  // One clock: observe DUT, then drive this cycle's inputs.
  task automatic step();
    logic exp_plot;
    pix_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (resetn) begin
      while (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc)
        void'(exp_q.pop_front());
      exp_plot = (exp_q.size() > 0) && (exp_q[0].cyc + 1 == cyc);
      chk("vga_plot", 64'(vga_plot), 64'(exp_plot));
      if (exp_plot && vga_plot) begin
        e = exp_q.pop_front();
        plot_cnt++;
        chk("vga_x", 64'(vga_x), 64'(e.x));
        chk("vga_y", 64'(vga_y), 64'(e.y));
        chk("vga_color", 64'(vga_color), 64'(e.c));
      end
      if (enable_draw != '0) begin
        en_log.push_back(enable_draw);
        en_cyc.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (frame_overrun) ov_cnt++;
      if (layer_timeout != '0 && to_cyc < 0) to_cyc = cyc;
    end
    frame_tick = tick_req;
    tick_req   = 1'b0;
    layer_we   = '0;
    layer_done = '0;
    for (int i = 0; i < NL; i++) begin
      if (!resetn) begin
        ph[i] = 0;
      end else if (ph[i] >= 1 && ph[i] <= 4) begin
        layer_x[i*9 +: 9]       = px_x(i, ph[i] - 1);
        layer_y[i*8 +: 8]       = px_y(i, ph[i] - 1);
        layer_color[i*12 +: 12] = px_c(i, ph[i] - 1);
        layer_we[i] = 1'b1;
        e.cyc = cyc;
        e.x   = px_x(i, ph[i] - 1);
        e.y   = px_y(i, ph[i] - 1);
        e.c   = px_c(i, ph[i] - 1);
        exp_q.push_back(e);
        ph[i]++;
      end else if (ph[i] == 5) begin
        if (!hang[i]) begin
          layer_done[i] = 1'b1;
          done_cyc[i] = cyc;
        end
        ph[i] = 0;
      end
    end
    if (spur_en && ph[1] == 3) layer_done[0] = 1'b1;
    if (resetn) begin
      for (int i = 0; i < NL; i++)
        if (enable_draw[i]) ph[i] = 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_frame(input logic [NL-1:0] m);
    layer_mask = m;
    tick_req = 1'b1;
    step();
    t0 = cyc;
  endtask

  function automatic logic [63:0] outs();
    return {23'd0, enable_draw, vga_x, vga_y, vga_color,
            vga_plot, busy, frame_done, frame_overrun,
            layer_timeout};
  endfunction

  initial begin
    for (int i = 0; i < NL; i++) begin
      ph[i] = 0;
      done_cyc[i] = -100;
    end
    clr();

    // Reset state
    run(3);
    chk("reset_outs", outs(), 64'd0);
    resetn = 1'b1;
    run(2);

    // Full mask: four stages in order
    clr();
    start_frame(4'b1111);
    run(40);
    chk("full_en_count", 64'(en_log.size()), 64'd4);
    if (en_log.size() == 4) begin
      for (int i = 0; i < 4; i++)
        chk("full_en_order", 64'(en_log[i]), 64'(1 << i));
      chk("full_en0_cycle", 64'(en_cyc[0]), 64'(t0 + 2));
    end
    chk("full_plots", 64'(plot_cnt), 64'd16);
    chk("full_frame_done", 64'(fd_cnt), 64'd1);
    chk("full_fd_cycle", 64'(fd_cyc), 64'(done_cyc[3] + 1));
    chk("full_busy_end", 64'(busy), 64'd0);
    chk("full_timeout", 64'(layer_timeout), 64'd0);

    // Sparse mask 1010
    clr();
    start_frame(4'b1010);
    run(30);
    chk("sparse_en_count", 64'(en_log.size()), 64'd2);
    if (en_log.size() == 2) begin
      chk("sparse_en_a", 64'(en_log[0]), 64'b0010);
      chk("sparse_en_b", 64'(en_log[1]), 64'b1000);
    end
    chk("sparse_plots", 64'(plot_cnt), 64'd8);
    chk("sparse_fd_cycle", 64'(fd_cyc), 64'(done_cyc[3] + 1));

    // Empty mask
    clr();
    start_frame(4'b0000);
    chk("empty_busy_start", 64'(busy), 64'd0);
    run(12);
    chk("empty_fd_cycle", 64'(fd_cyc), 64'(t0 + 5));
    chk("empty_fd_count", 64'(fd_cnt), 64'd1);
    chk("empty_en_count", 64'(en_log.size()), 64'd0);
    chk("empty_plots", 64'(plot_cnt), 64'd0);

    // Hung stage 2 and a stray done on stage 0
    clr();
    hang    = 4'b0100;
    spur_en = 1'b1;
    start_frame(4'b1111);
    run(60);
    hang    = '0;
    spur_en = 1'b0;
    chk("to_flags", 64'(layer_timeout), 64'b0100);
    chk("to_en_count", 64'(en_log.size()), 64'd4);
    if (en_log.size() == 4) begin
      chk("to_stage1_len", 64'(en_cyc[2] - en_cyc[1]), 64'd7);
      chk("to_wd_cycle", 64'(to_cyc), 64'(en_cyc[2] + 17));
      chk("to_next_en", 64'(en_cyc[3]), 64'(to_cyc + 1));
      chk("to_en3", 64'(en_log[3]), 64'b1000);
    end
    chk("to_fd_count", 64'(fd_cnt), 64'd1);
    chk("to_plots", 64'(plot_cnt), 64'd16);

    // Overrun: two extra ticks during a busy frame
    clr();
    layer_mask = 4'b0001;
    for (int k = 0; k < 40; k++) begin
      tick_req = (k == 0 || k == 3 || k == 5);
      step();
      if (k == 0) t0 = cyc;
    end
    chk("ovr_pulses", 64'(ov_cnt), 64'd1);
    chk("ovr_frames", 64'(fd_cnt), 64'd2);
    chk("ovr_en_count", 64'(en_log.size()), 64'd2);
    chk("ovr_busy_end", 64'(busy), 64'd0);

    // Reset in the middle of stage 1
    clr();
    start_frame(4'b1111);
    for (int k = 0; k < 60 && en_log.size() < 2; k++) step();
    chk("rst_reach_stage1", 64'(en_log.size()), 64'd2);
    run(3);
    chk("rst_pre_plot", 64'(vga_plot), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_outs_immediate", outs(), 64'd0);
    run(2);
    chk("rst_outs_held", outs(), 64'd0);
    resetn = 1'b1;
    exp_q.delete();
    clr();
    run(2);
    start_frame(4'b1111);
    run(40);
    chk("rst_en_count", 64'(en_log.size()), 64'd4);
    if (en_log.size() > 0)
      chk("rst_first_en", 64'(en_log[0]), 64'b0001);
    chk("rst_fd_count", 64'(fd_cnt), 64'd1);
    chk("rst_plots", 64'(plot_cnt), 64'd16);
    chk("rst_timeout_clear", 64'(layer_timeout), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
